// File: rtl/output_dev_arbiter.sv
// Round-robin arbiter sharing the single write port of the output device
// between the CPU store path (port 0) and the debug/loader path (port 1).
// One device write per grant, followed by a programmable idle gap.
module output_dev_arbiter #(
    parameter int unsigned DW  = 32,
    parameter int unsigned GAP = 2,
    parameter int unsigned CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          sel0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic          sel1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    output logic          dev_we,
    output logic          dev_sel,
    output logic [DW-1:0] dev_data,
    output logic          grant_id,
    output logic          busy,
    output logic [CW-1:0] wr_count
);

    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic [GW-1:0]   cnt_q, cnt_d;
    logic            win;
    logic            ack0_d, ack1_d, we_d, sel_d, grant_d, busy_d;
    logic [DW-1:0]   data_d;
    logic [CW-1:0]   wr_count_d;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        win        = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        we_d       = 1'b0;
        sel_d      = dev_sel;
        data_d     = dev_data;
        grant_d    = grant_id;
        wr_count_d = wr_count;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // A lone request wins outright; the pointer only breaks ties.
                    win      = (req0 && req1) ? ptr_q : req1;
                    state_d  = ST_WRITE;
                    we_d     = 1'b1;
                    ack0_d   = ~win;
                    ack1_d   = win;
                    sel_d    = win ? sel1 : sel0;
                    data_d   = win ? data1 : data0;
                    grant_d  = win;
                    ptr_d    = ~win;
                end
            end
            ST_WRITE: begin
                wr_count_d = wr_count + CW'(1);
                if (GAP > 0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops the write strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            dev_we   <= 1'b0;
            dev_sel  <= 1'b0;
            dev_data <= '0;
            grant_id <= 1'b0;
            busy     <= 1'b0;
            wr_count <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            dev_we   <= we_d;
            dev_sel  <= sel_d;
            dev_data <= data_d;
            grant_id <= grant_d;
            busy     <= busy_d;
            wr_count <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_output_dev_arbiter.sv
// Directed bench for output_dev_arbiter: instance a (GAP=2, CW=4) and
// instance b (GAP=0, CW=16) share one set of requester inputs.
module tb_output_dev_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, sel0, req1, sel1;
    logic [31:0] data0, data1;

    logic        a_ack0, a_ack1, a_we, a_sel, a_gid, a_busy;
    logic [31:0] a_data;
    logic [3:0]  a_cnt;
    logic        b_ack0, b_ack1, b_we, b_sel, b_gid, b_busy;
    logic [31:0] b_data;
    logic [15:0] b_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last   = 0;

    output_dev_arbiter #(.DW(32), .GAP(2), .CW(4)) u_a (
        .clk(clk), .rst(rst),
        .req0(req0), .sel0(sel0), .data0(data0), .ack0(a_ack0),
        .req1(req1), .sel1(sel1), .data1(data1), .ack1(a_ack1),
        .dev_we(a_we), .dev_sel(a_sel), .dev_data(a_data),
        .grant_id(a_gid), .busy(a_busy), .wr_count(a_cnt)
    );

    output_dev_arbiter #(.DW(32), .GAP(0), .CW(16)) u_b (
        .clk(clk), .rst(rst),
        .req0(req0), .sel0(sel0), .data0(data0), .ack0(b_ack0),
        .req1(req1), .sel1(sel1), .data1(data1), .ack1(b_ack1),
        .dev_we(b_we), .dev_sel(b_sel), .dev_data(b_data),
        .grant_id(b_gid), .busy(b_busy), .wr_count(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until the chosen instance pulses dev_we, within a cycle budget.
    task automatic wait_we(input bit which, input int budget, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            hit = which ? b_we : a_we;
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=no_dev_we expected=dev_we within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b1; sel0 = 1'b0; data0 = 32'h1234_5678;
        req1 = 1'b0; sel1 = 1'b0; data1 = 32'h0;
        tick(); tick(); tick();

        // Reset holds every output at zero even with a request present.
        chk("rst_we",   64'(a_we),   64'd0);
        chk("rst_ack0", 64'(a_ack0), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_cnt",  64'(a_cnt),  64'd0);
        chk("rst_data", 64'(a_data), 64'd0);
        chk("rst_gid",  64'(a_gid),  64'd0);
        chk("rst_b_we", 64'(b_we),   64'd0);

        // First edge after release grants port 0.
        rst = 1'b0;
        tick();
        chk("w1_we",   64'(a_we),   64'd1);
        chk("w1_ack0", 64'(a_ack0), 64'd1);
        chk("w1_ack1", 64'(a_ack1), 64'd0);
        chk("w1_sel",  64'(a_sel),  64'd0);
        chk("w1_data", 64'(a_data), 64'h1234_5678);
        chk("w1_gid",  64'(a_gid),  64'd0);
        chk("w1_busy", 64'(a_busy), 64'd1);
        chk("w1_cnt",  64'(a_cnt),  64'd0);
        chk("w1_b_we", 64'(b_we),   64'd1);
        req0 = 1'b0;
        tick();
        chk("w1_we_off",  64'(a_we),   64'd0);
        chk("w1_ack_off", 64'(a_ack0), 64'd0);
        chk("w1_cnt1",    64'(a_cnt),  64'd1);
        chk("w1_b_cnt1",  64'(b_cnt),  64'd1);
        chk("w1_b_busy",  64'(b_busy), 64'd0);
        tick();
        chk("gap_busy", 64'(a_busy), 64'd1);
        chk("gap_we",   64'(a_we),   64'd0);
        tick();
        chk("idle_busy", 64'(a_busy), 64'd0);
        chk("hold_data", 64'(a_data), 64'h1234_5678);

        // Contention on instance a: grants alternate, pulses 4 cycles apart.
        rst = 1'b1;
        req0 = 1'b1; sel0 = 1'b0; data0 = 32'hA;
        req1 = 1'b1; sel1 = 1'b1; data1 = 32'hB;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_we(1'b0, 6, "cont_wait");
            chk("cont_gid",  64'(a_gid),  64'(i % 2));
            chk("cont_data", 64'(a_data), (i % 2) ? 64'hB : 64'hA);
            chk("cont_sel",  64'(a_sel),  64'(i % 2));
            chk("cont_ack1", 64'(a_ack1), 64'(i % 2));
            chk("cont_ack0", 64'(a_ack0), 64'((i + 1) % 2));
            if (i > 0) chk("cont_space", 64'(cyc - last), 64'd4);
            last = cyc;
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // GAP=0 on instance b: port 1 alone, one write every 2 cycles.
        req1 = 1'b1; sel1 = 1'b1; data1 = 32'hC0DE_0001;
        for (int i = 0; i < 4; i++) begin
            wait_we(1'b1, 4, "g0_wait");
            chk("g0_gid",  64'(b_gid),  64'd1);
            chk("g0_sel",  64'(b_sel),  64'd1);
            chk("g0_ack1", 64'(b_ack1), 64'd1);
            chk("g0_data", 64'(b_data), 64'hC0DE_0001);
            if (i > 0) chk("g0_space", 64'(cyc - last), 64'd2);
            last = cyc;
        end
        req1 = 1'b0;
        req0 = 1'b1; sel0 = 1'b0; data0 = 32'h55;
        wait_we(1'b1, 4, "g0_p0_wait");
        chk("g0_p0_space", 64'(cyc - last), 64'd2);
        chk("g0_p0_gid",   64'(b_gid),  64'd0);
        chk("g0_p0_ack0",  64'(b_ack0), 64'd1);
        chk("g0_p0_data",  64'(b_data), 64'h55);
        req0 = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Reset in the middle of a write cancels it without counting it.
        req0 = 1'b1; data0 = 32'h77;
        wait_we(1'b0, 6, "mid_wait");
        rst = 1'b1;
        #1;
        chk("mid_we",   64'(a_we),   64'd0);
        chk("mid_ack0", 64'(a_ack0), 64'd0);
        chk("mid_cnt",  64'(a_cnt),  64'd0);
        chk("mid_busy", 64'(a_busy), 64'd0);
        tick();
        rst = 1'b0;
        wait_we(1'b0, 2, "mid_regrant");
        chk("mid_rg_ack0", 64'(a_ack0), 64'd1);
        chk("mid_rg_data", 64'(a_data), 64'h77);
        tick();
        chk("mid_rg_cnt", 64'(a_cnt), 64'd1);

        // Counter wrap on the 4-bit instance: writes 2..17 with req0 held.
        for (int n = 2; n <= 17; n++) begin
            wait_we(1'b0, 6, "wrap_wait");
            tick();
            chk("wrap_cnt", 64'(a_cnt), 64'(n % 16));
        end
        req0 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_dev_arbiter.md
# output_dev_arbiter

Sequencing controller that shares the single write port of the 32-bit output device between two requesters: port 0 is the CPU store path and port 1 is the debug/loader path. Grants are round-robin, one device write per grant, with a programmable minimum idle gap between consecutive device writes. The controller drives the device's `we`, `sel_signal` and `Data_in` directly. It reports which port was granted last and counts completed writes.

## Interface
Parameters:
- `DW`, 32, data width; matches the device data port.
- `GAP`, 2, minimum idle cycles between consecutive `dev_we` pulses; 0 is legal.
- `CW`, 16, width of the write counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  port 0 write request; held high until `ack0`.
- `sel0`  in  1  port 0 select: 1 = update current only, 0 = load initial and current.
- `data0`  in  DW  port 0 write data; stable while `req0` is high.
- `ack0`  out  1  one-cycle pulse; port 0 write issued this cycle.
- `req1`, `sel1`, `data1`, `ack1`: same definitions for port 1.
- `dev_we`  out  1  device write enable, one-cycle pulse.
- `dev_sel`  out  1  device `sel_signal`.
- `dev_data`  out  DW  device `Data_in`.
- `grant_id`  out  1  port that received the most recent grant.
- `busy`  out  1  high in the WRITE and GAP states.
- `wr_count`  out  CW  number of `dev_we` pulses issued, modulo 2^CW.

## Operation
- The state machine has three states: IDLE, WRITE and GAP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that port, regardless of the priority pointer.
  - If both requests are high, grant the port named by the priority pointer `ptr`.
  - On a grant: load `dev_sel` and `dev_data` from the winning port, set `grant_id`, and go to WRITE.
  - After every grant, set `ptr` to the complement of the granted port.
- WRITE: `dev_we` is 1 and the winner's `ack` is 1 for exactly this one cycle, and `wr_count` increments at the end of the cycle. The next state is GAP if GAP>0, otherwise IDLE. The GAP counter loads GAP-1.
- GAP: `dev_we` is 0. Decrement the counter and return to IDLE on the cycle the counter is 0. Requests are not sampled in GAP.
- `dev_sel` and `dev_data` hold their last granted values until the next grant; they are never cleared except by reset.
- `wr_count` wraps from 2^CW-1 to 0.
- Requester rule: a requester may deassert `req` or present new data in the cycle after `ack`. A request still high in IDLE is treated as a new transfer.
- No buffering inside the block: the data is captured only at the grant edge.

## Timing
- All outputs are registered, so there are no combinational paths from inputs to outputs.
- Reset forces: state IDLE, `ptr` 0, `grant_id` 0, `dev_we` 0, `ack0` 0, `ack1` 0, `dev_sel` 0, `dev_data` 0, `busy` 0, `wr_count` 0.
- Latency: a request that is high at rising edge E while in IDLE produces `dev_we` and `ack` during the cycle E→E+1.
- Continuous requests give one write every 2+GAP cycles.
- Reset asserted mid-WRITE or mid-GAP:
  - `dev_we` and `ack` drop immediately (asynchronously).
  - The write in flight is not counted if reset arrives before the WRITE edge.
  - The requester keeps `req` high and is re-arbitrated after reset release.
- Reset deasserted: the first grant can occur at the first rising edge with a request present.
- A request arriving during WRITE or GAP waits; it is sampled at the first IDLE edge.

## Test plan
- Reset: assert `rst` with requests active → all outputs 0. Release → with `req0`=1, `sel0`=0, `data0`=0x12345678, the first edge grants port 0.
- Single write (`req0`=1, `sel0`=0, `data0`=0x12345678):
  - One cycle later: `dev_we`=1, `ack0`=1, `dev_sel`=0, `dev_data`=0x12345678, `grant_id`=0.
  - Next cycle: `wr_count`=1.
  - `dev_we` stays high for exactly 1 cycle.
- Contention (GAP=2, `req0` and `req1` held high, `data0`=0xA, `data1`=0xB):
  - Grants go 0, 1, 0, 1.
  - `dev_data` goes 0xA, 0xB, 0xA, 0xB.
  - `dev_we` pulses are exactly 4 cycles apart.
- GAP=0 with `req1` only, repeated four times with `sel1`=1 → `grant_id`=1 every time and `dev_we` every 2 cycles. Port 0 then requests with `req1` low → granted immediately.
- Reset mid-WRITE (assert `rst` while `dev_we`=1):
  - `dev_we` and `ack` go to 0 in the same cycle, and `wr_count`=0.
  - After release, the still-pending request is granted.
- Wrap (CW=4): issue 17 writes → `wr_count` reads 15 after 15 writes, 0 after 16, and 1 after 17.
